framed_shift_register: RTL and testbench

- Parametrised successor of the team's 8-bit SPI-style shift register.
- Adds programmable width, selectable MSB-/LSB-first order, a frame bit counter, a busy flag, a received-word holding register, and a one-cycle frame-done pulse.
- Sits between the SPI edge detector, which supplies peripheralClkEdge, and the memory/config register file.
- Transmits a loaded word and captures a received word of WIDTH bits in each frame.

---
 rtl/framed_shift_register.sv | 90 +++++++++
 tb/tb_framed_shift_register.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/framed_shift_register.sv
// Framed SPI-style shift register: loads a WIDTH-bit word and shifts one bit per strobe, MSB- or LSB-first.
// Load->busy 1 cycle; last strobe->frameDone/rxData/busy-low 1 cycle; strobes outside a frame are ignored.
module framed_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic             lsbFirst,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             frameDone
);
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        shifted = order_q ? {serialDataIn, shreg_q[WIDTH-1:1]}
                          : {shreg_q[WIDTH-2:0], serialDataIn};
    end

    // Load wins over a coincident strobe and restarts any frame in progress.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        done_d  = 1'b0;
        if (parallelLoad) begin
            state_d = SHIFT;
            shreg_d = parallelDataIn;
            order_d = lsbFirst;
            cnt_d   = '0;
        end else if (state_q == SHIFT && peripheralClkEdge) begin
            shreg_d = shifted;
            if (cnt_q == LAST_BIT) begin
                state_d = IDLE;
                rx_d    = shifted;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    assign serialDataOut   = order_q ? shreg_q[0] : shreg_q[WIDTH-1];
    assign parallelDataOut = shreg_q;
    assign rxData          = rx_q;
    assign busy            = (state_q == SHIFT);
    assign frameDone       = done_q;

endmodule

// File: tb/tb_framed_shift_register.sv
// Directed bench for framed_shift_register: 8-bit and 16-bit instances, hand-computed expectations.
module tb_framed_shift_register;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n, edge8, pl8, lsb8, sin8;
    logic [7:0]  din8;
    logic        sout8, busy8, fd8;
    logic [7:0]  pdo8, rx8;

    logic        rst16_n, edge16, pl16, lsb16, sin16;
    logic [15:0] din16;
    logic        sout16, busy16, fd16;
    logic [15:0] pdo16, rx16;

    int checks = 0;
    int passes = 0;
    int dcnt8  = 0;
    int dcnt16 = 0;

    framed_shift_register #(.WIDTH(8)) u8 (
        .clk(clk), .resetN(rst8_n), .peripheralClkEdge(edge8), .parallelLoad(pl8),
        .lsbFirst(lsb8), .parallelDataIn(din8), .serialDataIn(sin8),
        .serialDataOut(sout8), .parallelDataOut(pdo8), .rxData(rx8),
        .busy(busy8), .frameDone(fd8)
    );

    framed_shift_register #(.WIDTH(16)) u16 (
        .clk(clk), .resetN(rst16_n), .peripheralClkEdge(edge16), .parallelLoad(pl16),
        .lsbFirst(lsb16), .parallelDataIn(din16), .serialDataIn(sin16),
        .serialDataOut(sout16), .parallelDataOut(pdo16), .rxData(rx16),
        .busy(busy16), .frameDone(fd16)
    );

    // frameDone is high for a whole cycle, so the falling edge sees each pulse exactly once.
    always @(negedge clk) begin
        if (fd8 === 1'b1)  dcnt8++;
        if (fd16 === 1'b1) dcnt16++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] d, input logic lsb);
        pl8 = 1'b1; din8 = d; lsb8 = lsb;
        tick();
        pl8 = 1'b0;
    endtask

    task automatic strobe8(input logic b);
        edge8 = 1'b1; sin8 = b;
        tick();
        edge8 = 1'b0;
    endtask

    task automatic strobe16(input logic b);
        edge16 = 1'b1; sin16 = b;
        tick();
        edge16 = 1'b0;
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst16_n = 1'b0;
        tick(); tick();
        checks++; if (pdo8 !== 8'h00) $display("FAIL reset_pdo got=%h exp=00", pdo8); else passes++;
        checks++; if (rx8 !== 8'h00) $display("FAIL reset_rx got=%h exp=00", rx8); else passes++;
        checks++; if ({busy8, fd8, sout8} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy8, fd8, sout8}); else passes++;
        checks++; if (pdo16 !== 16'h0000) $display("FAIL reset_pdo16 got=%h exp=0000", pdo16); else passes++;
        rst8_n = 1'b1; rst16_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) strobe8(1'b1);
        checks++; if (pdo8 !== 8'h00) $display("FAIL idle_strobe_pdo got=%h exp=00", pdo8); else passes++;
        checks++; if (busy8 !== 1'b0) $display("FAIL idle_strobe_busy got=%b exp=0", busy8); else passes++;
        checks++; if (dcnt8 !== 0) $display("FAIL idle_strobe_done got=%0d exp=0", dcnt8); else passes++;
    endtask

    task automatic test_msb_loopback();
        logic [7:0] exp_bits;
        int d0;
        exp_bits = 8'hA5;
        d0 = dcnt8;
        load8(8'hA5, 1'b0);
        checks++; if (busy8 !== 1'b1) $display("FAIL msb_busy_after_load got=%b exp=1", busy8); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sout8 !== exp_bits[7-i]) $display("FAIL msb_sout bit=%0d got=%b exp=%b", i, sout8, exp_bits[7-i]);
            else passes++;
            strobe8(sout8);
            if (i < 7) begin
                tick(); tick();
            end
            if (i == 6) begin
                checks++;
                if (busy8 !== 1'b1 || dcnt8 !== d0) $display("FAIL msb_early_done busy=%b pulses=%0d exp busy=1 pulses=%0d", busy8, dcnt8, d0);
                else passes++;
            end
        end
        checks++; if (fd8 !== 1'b1) $display("FAIL msb_done_pulse got=%b exp=1", fd8); else passes++;
        checks++; if (rx8 !== 8'hA5) $display("FAIL msb_rx got=%h exp=a5", rx8); else passes++;
        checks++; if (busy8 !== 1'b0) $display("FAIL msb_busy_end got=%b exp=0", busy8); else passes++;
        strobe8(1'b0);
        checks++; if (fd8 !== 1'b0) $display("FAIL msb_done_width got=%b exp=0", fd8); else passes++;
        checks++; if (pdo8 !== 8'hA5) $display("FAIL msb_hold_after_frame got=%h exp=a5", pdo8); else passes++;
        checks++; if (dcnt8 - d0 !== 1) $display("FAIL msb_pulse_count got=%0d exp=1", dcnt8 - d0); else passes++;
    endtask

    task automatic test_lsb_receive();
        logic [7:0] rx_bits;
        logic [7:0] tx_seen;
        rx_bits = 8'b1000_0011;
        tx_seen = 8'h00;
        load8(8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tx_seen[i] = sout8;
            strobe8(rx_bits[i]);
        end
        checks++; if (rx8 !== 8'h83) $display("FAIL lsb_rx got=%h exp=83", rx8); else passes++;
        checks++; if (tx_seen !== 8'h00) $display("FAIL lsb_tx_bits got=%h exp=00", tx_seen); else passes++;
        checks++; if (fd8 !== 1'b1) $display("FAIL lsb_done got=%b exp=1", fd8); else passes++;
        tick();
    endtask

    task automatic test_abort_restart();
        logic [7:0] bits;
        int d0;
        bits = 8'h69;
        d0 = dcnt8;
        load8(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) strobe8(1'b0);
        load8(8'h3C, 1'b0);
        checks++; if (pdo8 !== 8'h3C) $display("FAIL abort_reload_pdo got=%h exp=3c", pdo8); else passes++;
        checks++; if (rx8 !== 8'h83) $display("FAIL abort_rx_kept got=%h exp=83", rx8); else passes++;
        for (int i = 0; i < 7; i++) strobe8(bits[7-i]);
        checks++;
        if (busy8 !== 1'b1 || fd8 !== 1'b0 || dcnt8 !== d0) $display("FAIL abort_no_early_done busy=%b done=%b pulses=%0d exp busy=1 done=0 pulses=%0d", busy8, fd8, dcnt8, d0);
        else passes++;
        strobe8(bits[0]);
        checks++; if (fd8 !== 1'b1) $display("FAIL abort_done_8th got=%b exp=1", fd8); else passes++;
        checks++; if (rx8 !== 8'h69) $display("FAIL abort_rx got=%h exp=69", rx8); else passes++;
        tick();
    endtask

    task automatic test_load_priority();
        pl8 = 1'b1; edge8 = 1'b1; din8 = 8'h81; lsb8 = 1'b0; sin8 = 1'b0;
        tick();
        pl8 = 1'b0; edge8 = 1'b0;
        checks++; if (pdo8 !== 8'h81) $display("FAIL prio_pdo got=%h exp=81", pdo8); else passes++;
        checks++; if (busy8 !== 1'b1) $display("FAIL prio_busy got=%b exp=1", busy8); else passes++;
        for (int i = 0; i < 7; i++) strobe8(1'b1);
        checks++; if (busy8 !== 1'b1 || fd8 !== 1'b0) $display("FAIL prio_count busy=%b done=%b exp busy=1 done=0", busy8, fd8); else passes++;
        strobe8(1'b1);
        checks++; if (fd8 !== 1'b1 || rx8 !== 8'hFF) $display("FAIL prio_frame done=%b rx=%h exp done=1 rx=ff", fd8, rx8); else passes++;
        tick();
    endtask

    task automatic test_reset_midframe_w16();
        int d0;
        d0 = dcnt16;
        pl16 = 1'b1; din16 = 16'hBEEF; lsb16 = 1'b0;
        tick();
        pl16 = 1'b0;
        for (int i = 0; i < 5; i++) strobe16(1'b0);
        rst16_n = 1'b0;
        tick();
        rst16_n = 1'b1;
        checks++; if (pdo16 !== 16'h0000 || rx16 !== 16'h0000) $display("FAIL rst16_regs pdo=%h rx=%h exp 0000/0000", pdo16, rx16); else passes++;
        checks++; if ({busy16, fd16, sout16} !== 3'b000) $display("FAIL rst16_flags got=%b exp=000", {busy16, fd16, sout16}); else passes++;
        tick();
        checks++; if (dcnt16 !== d0) $display("FAIL rst16_no_done got=%0d exp=%0d", dcnt16, d0); else passes++;
        pl16 = 1'b1; din16 = 16'h0000;
        tick();
        pl16 = 1'b0;
        for (int i = 0; i < 15; i++) strobe16(1'b1);
        checks++; if (busy16 !== 1'b1 || fd16 !== 1'b0) $display("FAIL w16_before_last busy=%b done=%b exp busy=1 done=0", busy16, fd16); else passes++;
        strobe16(1'b1);
        checks++; if (rx16 !== 16'hFFFF) $display("FAIL w16_rx got=%h exp=ffff", rx16); else passes++;
        checks++; if (fd16 !== 1'b1 || busy16 !== 1'b0) $display("FAIL w16_end done=%b busy=%b exp done=1 busy=0", fd16, busy16); else passes++;
        tick();
        checks++; if (dcnt16 - d0 !== 1) $display("FAIL w16_pulse_count got=%0d exp=1", dcnt16 - d0); else passes++;
    endtask

    initial begin
        rst8_n = 1'b0; edge8 = 1'b0; pl8 = 1'b0; lsb8 = 1'b0; sin8 = 1'b0; din8 = '0;
        rst16_n = 1'b0; edge16 = 1'b0; pl16 = 1'b0; lsb16 = 1'b0; sin16 = 1'b0; din16 = '0;
        test_reset();
        test_msb_loopback();
        test_lsb_receive();
        test_abort_restart();
        test_load_priority();
        test_reset_midframe_w16();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
